rx_unit_param: RTL and testbench

RX_UNIT_PARAM -- requirements
Module: rx_unit_param

---
 rtl/rx_unit_param.sv | 237 +++++++++++++++++++++++
 tb/tb_rx_unit_param.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_unit_param.sv
// rx_unit_param: packet receiver. Decodes header/payload phits into SPM
// writes (64-bit, half-word enables), config writes (32-bit) and interrupt
// notifications.
// Notifications are queued in a small first-word-fall-through FIFO.
// The FIFO counts pushes that it drops.
//
// Handshake: a phit is consumed on any rising edge where pkt_in[34] (valid)
// is 1. There is no backpressure. irq_rd pops the FIFO head on the edge where
// it is sampled high, provided the FIFO is not empty. The head is always
// visible on irq_data/irq_is_data.
module rx_unit_param #(
  parameter int ADDR_W    = 14,
  parameter int IRQ_DEPTH = 4,
  parameter int OVF_W     = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [34:0]       pkt_in,
  output logic [ADDR_W-1:0] spm_addr,
  output logic [1:0]        spm_en,
  output logic              spm_wr,
  output logic [63:0]       spm_wdata,
  output logic [ADDR_W-1:0] config_addr,
  output logic              config_en,
  output logic              config_wr,
  output logic [31:0]       config_wdata,
  input  logic              irq_rd,
  output logic [ADDR_W-1:0] irq_data,
  output logic              irq_is_data,
  output logic              irq_empty,
  output logic              irq_full,
  output logic [OVF_W-1:0]  irq_ovf_cnt,
  output logic              pkt_err,
  output logic [2:0]        fsm_state
);

  localparam int PTR_W = (IRQ_DEPTH > 1) ? $clog2(IRQ_DEPTH) : 1;
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(IRQ_DEPTH);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    DATA_HI = 3'd1,
    DATA_LO = 3'd2,
    CFG     = 3'd3,
    IRQ     = 3'd4
  } state_t;

  state_t state, state_nxt;

  // Phit field decode
  logic        valid, sop, eop;
  logic [31:0] payload;
  logic        is_hdr, is_pay, is_bad;
  assign valid   = pkt_in[34];
  assign sop     = pkt_in[33];
  assign eop     = pkt_in[32];
  assign payload = pkt_in[31:0];
  assign is_hdr  = valid & sop & ~eop;
  assign is_pay  = valid & ~sop;
  // sop together with eop is not a legal phit; it is flagged and dropped
  assign is_bad  = valid & sop & eop;

  // Per-packet context
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] hdr_addr;
  logic [31:0]       high;
  logic              last_flag;

  // Decoded actions for the current phit
  logic        spm_go, cfg_go, hi_load, addr_load, addr_inc;
  logic [1:0]  spm_en_nxt;
  logic [63:0] spm_wdata_nxt;
  logic        push_req, push_is_data, err_nxt;

  // FIFO status
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count;
  logic [ADDR_W:0]  mem [IRQ_DEPTH];
  logic             push_ok, pop_ok;

  assign fsm_state = state;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and per-phit action decode
  always_comb begin
    state_nxt     = state;
    spm_go        = 1'b0;
    spm_en_nxt    = 2'b00;
    spm_wdata_nxt = 64'd0;
    cfg_go        = 1'b0;
    hi_load       = 1'b0;
    addr_load     = 1'b0;
    addr_inc      = 1'b0;
    push_req      = 1'b0;
    push_is_data  = 1'b0;
    err_nxt       = 1'b0;
    if (is_hdr) begin
      // A header always starts a new packet; outside IDLE it is also an error
      err_nxt   = (state != IDLE);
      addr_load = 1'b1;
      case (payload[31:30])
        2'b01:   state_nxt = CFG;
        2'b11:   state_nxt = IRQ;
        default: state_nxt = DATA_HI;
      endcase
    end else if (is_bad) begin
      err_nxt = 1'b1;
    end else if (is_pay) begin
      case (state)
        IDLE: err_nxt = 1'b1;
        DATA_HI: begin
          if (!eop) begin
            hi_load   = 1'b1;
            state_nxt = DATA_LO;
          end else begin
            spm_go        = 1'b1;
            spm_en_nxt    = 2'b10;
            spm_wdata_nxt = {payload, 32'd0};
            push_req      = last_flag;
            push_is_data  = 1'b1;
            state_nxt     = IDLE;
          end
        end
        DATA_LO: begin
          spm_go        = 1'b1;
          spm_en_nxt    = 2'b11;
          spm_wdata_nxt = {high, payload};
          addr_inc      = 1'b1;
          if (eop) begin
            push_req     = last_flag;
            push_is_data = 1'b1;
            state_nxt    = IDLE;
          end else begin
            state_nxt = DATA_HI;
          end
        end
        CFG: begin
          cfg_go   = 1'b1;
          addr_inc = 1'b1;
          if (eop) state_nxt = IDLE;
        end
        IRQ: begin
          if (eop) begin
            push_req  = 1'b1;
            state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Packet context: running address, header address, high word, last flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr      <= '0;
      hdr_addr  <= '0;
      high      <= '0;
      last_flag <= 1'b0;
    end else begin
      if (addr_load) begin
        addr      <= payload[16+ADDR_W-1:16];
        hdr_addr  <= payload[16+ADDR_W-1:16];
        high      <= '0;
        last_flag <= payload[31] & ~payload[30];
      end else if (addr_inc) begin
        addr <= addr + ADDR_W'(1);
      end
      if (hi_load) high <= payload;
    end
  end

  // Registered write ports and error pulse; strobes last exactly one cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      spm_wr       <= 1'b0;
      spm_en       <= 2'b00;
      spm_addr     <= '0;
      spm_wdata    <= '0;
      config_wr    <= 1'b0;
      config_en    <= 1'b0;
      config_addr  <= '0;
      config_wdata <= '0;
      pkt_err      <= 1'b0;
    end else begin
      spm_wr    <= spm_go;
      spm_en    <= spm_en_nxt;
      config_wr <= cfg_go;
      config_en <= cfg_go;
      pkt_err   <= err_nxt;
      if (spm_go) begin
        spm_addr  <= addr;
        spm_wdata <= spm_wdata_nxt;
      end
      if (cfg_go) begin
        config_addr  <= addr;
        config_wdata <= payload;
      end
    end
  end

  // Interrupt FIFO: a push while full is still taken if a pop frees a slot
  assign irq_empty   = (count == '0);
  assign irq_full    = (count == FULL_CNT);
  assign push_ok     = push_req & (~irq_full | irq_rd);
  assign pop_ok      = irq_rd & ~irq_empty;
  assign irq_data    = mem[rd_ptr][ADDR_W-1:0];
  assign irq_is_data = mem[rd_ptr][ADDR_W];

  // FIFO storage (no reset needed; validity is tracked by count)
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= {push_is_data, hdr_addr};
  end

  // FIFO pointers, occupancy and saturating drop counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      irq_ovf_cnt <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push_ok && !pop_ok)      count <= count + (PTR_W+1)'(1);
      else if (!push_ok && pop_ok) count <= count - (PTR_W+1)'(1);
      if (push_req && !push_ok && (irq_ovf_cnt != '1))
        irq_ovf_cnt <= irq_ovf_cnt + OVF_W'(1);
    end
  end

endmodule

// File: tb/tb_rx_unit_param.sv
// Directed testbench for rx_unit_param with default parameters
// (ADDR_W=14, IRQ_DEPTH=4, OVF_W=8).
module tb_rx_unit_param;

  logic        clk;
  logic        reset;
  logic [34:0] pkt_in;
  logic [13:0] spm_addr;
  logic [1:0]  spm_en;
  logic        spm_wr;
  logic [63:0] spm_wdata;
  logic [13:0] config_addr;
  logic        config_en;
  logic        config_wr;
  logic [31:0] config_wdata;
  logic        irq_rd;
  logic [13:0] irq_data;
  logic        irq_is_data;
  logic        irq_empty;
  logic        irq_full;
  logic [7:0]  irq_ovf_cnt;
  logic        pkt_err;
  logic [2:0]  fsm_state;

  int checks   = 0;
  int failures = 0;

  rx_unit_param dut (
    .clk(clk), .reset(reset), .pkt_in(pkt_in),
    .spm_addr(spm_addr), .spm_en(spm_en), .spm_wr(spm_wr), .spm_wdata(spm_wdata),
    .config_addr(config_addr), .config_en(config_en), .config_wr(config_wr),
    .config_wdata(config_wdata), .irq_rd(irq_rd), .irq_data(irq_data),
    .irq_is_data(irq_is_data), .irq_empty(irq_empty), .irq_full(irq_full),
    .irq_ovf_cnt(irq_ovf_cnt), .pkt_err(pkt_err), .fsm_state(fsm_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Drive one phit for one cycle; return 1ns after the edge that consumes it
  task automatic send(input logic s, input logic e, input logic [31:0] p);
    @(negedge clk);
    pkt_in = {1'b1, s, e, p};
    @(posedge clk);
    #1;
    pkt_in = '0;
  endtask

  task automatic hdr(input logic [1:0] typ, input logic [13:0] a);
    send(1'b1, 1'b0, {typ, 16'd0, 14'd0} | ({18'd0, a} << 16));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pop();
    @(negedge clk);
    irq_rd = 1'b1;
    @(posedge clk);
    #1;
    irq_rd = 1'b0;
  endtask

  task automatic irq_pkt(input logic [13:0] a);
    hdr(2'b11, a);
    send(1'b0, 1'b1, 32'h0000_0099);
  endtask

  initial begin
    pkt_in = '0;
    irq_rd = 1'b0;
    reset  = 1'b0;
    #12;
    // Reset values
    chk("rst_state", fsm_state, 3'd0);
    chk("rst_spm_wr", spm_wr, 1'b0);
    chk("rst_spm_en", spm_en, 2'b00);
    chk("rst_cfg_wr", config_wr, 1'b0);
    chk("rst_cfg_en", config_en, 1'b0);
    chk("rst_err", pkt_err, 1'b0);
    chk("rst_empty", irq_empty, 1'b1);
    chk("rst_full", irq_full, 1'b0);
    chk("rst_ovf", irq_ovf_cnt, 8'd0);
    @(negedge clk);
    reset = 1'b1;
    tick();

    // Data packet: two full words then a trailing high half
    hdr(2'b00, 14'h010);
    chk("d_hdr_wr", spm_wr, 1'b0);
    chk("d_hdr_err", pkt_err, 1'b0);
    send(1'b0, 1'b0, 32'h0000_000A);
    chk("d_a_wr", spm_wr, 1'b0);
    send(1'b0, 1'b0, 32'h0000_000B);
    chk("d_b_wr", spm_wr, 1'b1);
    chk("d_b_en", spm_en, 2'b11);
    chk("d_b_addr", spm_addr, 14'h010);
    chk("d_b_data", spm_wdata, 64'h0000_000A_0000_000B);
    send(1'b0, 1'b1, 32'h0000_000C);
    chk("d_c_wr", spm_wr, 1'b1);
    chk("d_c_en", spm_en, 2'b10);
    chk("d_c_addr", spm_addr, 14'h011);
    chk("d_c_data", spm_wdata[63:32], 32'h0000_000C);
    tick();
    chk("d_idle_wr", spm_wr, 1'b0);
    chk("d_idle_en", spm_en, 2'b00);
    chk("d_no_push", irq_empty, 1'b1);

    // Config packet with address wrap
    hdr(2'b01, 14'h3FFF);
    send(1'b0, 1'b0, 32'h0000_0001);
    chk("c1_wr", config_wr, 1'b1);
    chk("c1_en", config_en, 1'b1);
    chk("c1_addr", config_addr, 14'h3FFF);
    chk("c1_data", config_wdata, 32'h1);
    send(1'b0, 1'b1, 32'h0000_0002);
    chk("c2_wr", config_wr, 1'b1);
    chk("c2_addr", config_addr, 14'h0000);
    chk("c2_data", config_wdata, 32'h2);
    tick();
    chk("c_idle_wr", config_wr, 1'b0);
    chk("c_idle_en", config_en, 1'b0);
    chk("c_state", fsm_state, 3'd0);

    // Last-data packet then irq packet
    hdr(2'b10, 14'h020);
    send(1'b0, 1'b1, 32'h0000_0011);
    chk("ld_wr", spm_wr, 1'b1);
    chk("ld_addr", spm_addr, 14'h020);
    chk("ld_nonempty", irq_empty, 1'b0);
    irq_pkt(14'h005);
    chk("irq_no_spm", spm_wr, 1'b0);
    chk("irq_no_cfg", config_wr, 1'b0);
    chk("h1_data", irq_data, 14'h020);
    chk("h1_isdata", irq_is_data, 1'b1);
    pop();
    chk("h2_data", irq_data, 14'h005);
    chk("h2_isdata", irq_is_data, 1'b0);
    pop();
    chk("h_empty", irq_empty, 1'b1);

    // Overflow: IRQ_DEPTH+2 packets without popping
    for (int i = 0; i < 6; i++) begin
      irq_pkt(14'h100 + 14'(i));
      if (i == 3) chk("ovf_full4", irq_full, 1'b1);
    end
    chk("ovf_full", irq_full, 1'b1);
    chk("ovf_cnt2", irq_ovf_cnt, 8'd2);
    chk("ovf_head", irq_data, 14'h100);
    // Push coinciding with a pop while full
    hdr(2'b11, 14'h200);
    @(negedge clk);
    pkt_in = {3'b101, 32'h0000_0099};
    irq_rd = 1'b1;
    @(posedge clk);
    #1;
    pkt_in = '0;
    irq_rd = 1'b0;
    chk("pp_full", irq_full, 1'b1);
    chk("pp_cnt", irq_ovf_cnt, 8'd2);
    chk("pp_head", irq_data, 14'h101);
    pop();
    chk("pp_h102", irq_data, 14'h102);
    pop();
    chk("pp_h103", irq_data, 14'h103);
    pop();
    chk("pp_h200", irq_data, 14'h200);
    pop();
    chk("pp_empty", irq_empty, 1'b1);
    pop();
    chk("rd_empty_empty", irq_empty, 1'b1);
    chk("rd_empty_full", irq_full, 1'b0);
    irq_pkt(14'h0AB);
    chk("wrap_head", irq_data, 14'h0AB);
    pop();
    chk("wrap_empty", irq_empty, 1'b1);

    // Protocol errors
    send(1'b0, 1'b0, 32'h1234_5678);
    chk("e_idle_err", pkt_err, 1'b1);
    chk("e_idle_wr", spm_wr, 1'b0);
    tick();
    chk("e_err_pulse", pkt_err, 1'b0);
    hdr(2'b00, 14'h030);
    send(1'b0, 1'b0, 32'h0000_DEAD);
    chk("e_in_lo", fsm_state, 3'd2);
    hdr(2'b00, 14'h040);
    chk("e_hdr_err", pkt_err, 1'b1);
    chk("e_hdr_wr", spm_wr, 1'b0);
    send(1'b0, 1'b0, 32'h0000_0001);
    chk("e_p1_wr", spm_wr, 1'b0);
    chk("e_p1_err", pkt_err, 1'b0);
    send(1'b0, 1'b1, 32'h0000_0002);
    chk("e_p2_wr", spm_wr, 1'b1);
    chk("e_p2_addr", spm_addr, 14'h040);
    chk("e_p2_data", spm_wdata, 64'h0000_0001_0000_0002);

    // Drop counter saturation
    for (int i = 0; i < 264; i++) irq_pkt(14'h300);
    chk("sat_full", irq_full, 1'b1);
    chk("sat_cnt", irq_ovf_cnt, 8'hFF);

    // Reset mid-packet
    hdr(2'b00, 14'h050);
    send(1'b0, 1'b0, 32'h0000_0077);
    chk("r_in_lo", fsm_state, 3'd2);
    @(negedge clk);
    reset = 1'b0;
    pkt_in = {3'b101, 32'h0000_0088};
    #1;
    chk("r_state", fsm_state, 3'd0);
    chk("r_empty", irq_empty, 1'b1);
    chk("r_full", irq_full, 1'b0);
    chk("r_ovf", irq_ovf_cnt, 8'd0);
    tick();
    chk("r_wr", spm_wr, 1'b0);
    chk("r_err", pkt_err, 1'b0);
    @(negedge clk);
    pkt_in = '0;
    reset = 1'b1;
    send(1'b0, 1'b1, 32'h0000_0088);
    chk("r_orphan_err", pkt_err, 1'b1);
    chk("r_orphan_wr", spm_wr, 1'b0);
    hdr(2'b00, 14'h060);
    chk("r_hdr_err", pkt_err, 1'b0);
    send(1'b0, 1'b0, 32'h0000_0003);
    send(1'b0, 1'b1, 32'h0000_0004);
    chk("r_wr_ok", spm_wr, 1'b1);
    chk("r_addr", spm_addr, 14'h060);
    chk("r_data", spm_wdata, 64'h0000_0003_0000_0004);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
